cpu_sequencer: RTL
==================

Name: cpu_sequencer

Overview:
- Multi-cycle control FSM for the 64-bit core.
- Fetches 72-bit instructions over a req/ack instruction bus and holds them in the instruction register (ir_opc, ir_opl) that feeds the decoder.
- Sequences execute, memory and writeback by issuing one-cycle enable strobes to the ALU, register file and stack pointer, and drives the data-bus handshake.
- Owns the program counter.

Parameters:
- PC_W, 64, program counter / address width.
- INST_BYTES, 9, PC increment per sequential instruction.
- RESET_PC, 0, PC value loaded at reset.
- TIMEOUT_CYC, 255, bus-wait limit in cycles; used only with the optional feature.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_req  output  1  instruction fetch request.
- i_addr  output  PC_W  fetch address, equal to pc.
- i_ack  input  1  fetch complete; i_data valid this cycle.
- i_data  input  72  {opc[7:0], opl[63:0]}.
- d_req  output  1  data access request.
- d_we  output  1  1 = write, 0 = read.
- d_ack  input  1  data access complete.
- ir_opc  output  8  latched opcode.
- ir_opl  output  64  latched operand.
- alu_en  output  1  ALU result/flag capture strobe.
- rf_we  output  1  register-file write strobe.
- sp_inc  output  1  stack-pointer increment strobe.
- sp_dec  output  1  stack-pointer decrement strobe.
- br_taken  input  1  branch condition from the datapath, sampled in EXEC.
- br_target  input  PC_W  branch destination.
- pc  output  PC_W  current program counter.
- halted  output  1  core stopped.
- fault  output  1  bus timeout seen (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = FETCH, pc = RESET_PC, ir_opc = 0, ir_opl = 0.
  - All strobes, i_req, d_req, d_we, halted and fault = 0.
- Opcode classes use the constants from the shared instruction include:
  - STACK: PUSH, PUSHN, PUSHA, POP.
  - LOAD: opc[7]=1, opc[1]=0, not STACK.
  - STORE: opc[7]=1, opc[1]=1, not STACK.
  - JMP: the JMP constant.
  - HALT: the HALT constant.
  - ALU: everything else.
- FETCH:
  - i_req = 1 and held until i_ack; i_addr stable while i_req is high.
  - On i_ack: capture i_data into ir_opc/ir_opl, go to DECODE.
  - Without i_ack: stay in FETCH.
- DECODE: one cycle. Go to HALTED if HALT, otherwise EXEC.
- EXEC: one cycle, alu_en = 1.
  - PUSH/PUSHN/PUSHA: sp_dec = 1 in the same cycle.
  - JMP: if br_taken, pc <= br_target; else pc <= pc + INST_BYTES. Then FETCH.
  - ALU: go to WB.
  - LOAD, STORE, STACK: go to MEM.
- MEM:
  - d_req = 1 and held until d_ack.
  - d_we = 1 for STORE and PUSH*; d_we = 0 for LOAD and POP.
  - On d_ack: go to WB for LOAD/POP, else pc += INST_BYTES and go to FETCH.
- WB: one cycle, rf_we = 1.
  - POP: sp_inc = 1 in the same cycle.
  - pc <= pc + INST_BYTES, then FETCH.
- HALTED: halted = 1, absorbing state; only reset leaves it.
- Cycle counts: ALU 4 cycles plus fetch wait; LOAD 5 plus both waits.
- Strobes are combinational from state and class, and are high for exactly one cycle per instruction.
- pc arithmetic is modulo 2^PC_W and wraps silently at the top.
- Ack arriving in the same cycle as req is legal (zero-wait).
- Ack with no outstanding req is ignored.
- Reset mid-transfer drops req immediately; the sequencer does not wait for the ack.
- ir_* change only on a FETCH i_ack.

Optional Feature:
- Macro: SEQ_BUS_TIMEOUT_EN.
- Defined:
  - An 8-bit-or-wider wait counter clears on entry to FETCH or MEM and increments each cycle req is high without ack.
  - When the counter reaches TIMEOUT_CYC: drop req, set fault = 1, enter HALTED.
  - Ack in the same cycle as the limit counts as success.
- Undefined: no counter is built, fault is tied 0, and waits are unbounded.

Decomposition:
- Shared package/include:
  - State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5.
  - Opcode-class decode as a function or macros, reusing the existing PUSH/PUSHN/PUSHA/POP/JMP/HALT opcode constants.
- Sub-module: seq_bus_port, one req/ack channel holding req until ack, plus the timeout counter under the macro. Instantiated twice, for instruction and data.

Test Plan:
- ALU op, zero-wait acks, i_data={8'h04,64'h0102}: ir captured, alu_en in cycle 3, rf_we in cycle 4, pc 0->9.
- LOAD with d_ack delayed 3 cycles: d_req high 4 cycles, d_we=0, rf_we one cycle after d_ack, pc +9.
- PUSH then POP: sp_dec in PUSH EXEC with a d_we=1 transfer; POP gives a d_we=0 transfer then sp_inc and rf_we together in WB.
- JMP: br_taken=1 with br_target=64'h40 gives next i_addr=64'h40; br_taken=0 gives i_addr=pc+9. pc=2^64-4 with an ALU op wraps to 5.
- HALT opcode: halted=1 after DECODE, no further i_req; rst_n pulse mid-FETCH returns to FETCH at RESET_PC with i_req dropped asynchronously.
- With SEQ_BUS_TIMEOUT_EN and TIMEOUT_CYC=4, i_ack never asserted: fault=1 and halted=1 after 4 wait cycles. Ack at exactly cycle 4 means no fault.

Source files
------------

// File: rtl/cpu_sequencer_pkg.sv
// Shared state encodings, opcode constants and opcode-class decode for the
// cpu_sequencer control FSM.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALTED = 3'd5
  } seq_state_e;

  localparam logic [7:0] OPC_PUSH  = 8'hC0;
  localparam logic [7:0] OPC_PUSHN = 8'hC1;
  localparam logic [7:0] OPC_PUSHA = 8'hC2;
  localparam logic [7:0] OPC_POP   = 8'hC3;
  localparam logic [7:0] OPC_JMP   = 8'h20;
  localparam logic [7:0] OPC_HALT  = 8'h01;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_PUSH,
    CLS_POP,
    CLS_JMP,
    CLS_HALT
  } op_class_e;

  // Stack opcodes live in the opc[7]=1 space, so they must win over LOAD/STORE.
  function automatic op_class_e op_class(input logic [7:0] opc);
    op_class_e cls;
    if (opc == OPC_PUSH || opc == OPC_PUSHN || opc == OPC_PUSHA) cls = CLS_PUSH;
    else if (opc == OPC_POP)  cls = CLS_POP;
    else if (opc == OPC_JMP)  cls = CLS_JMP;
    else if (opc == OPC_HALT) cls = CLS_HALT;
    else if (opc[7])          cls = opc[1] ? CLS_STORE : CLS_LOAD;
    else                      cls = CLS_ALU;
    return cls;
  endfunction

endpackage

// File: rtl/cpu_sequencer_bus_port.sv
// One req/ack channel of the sequencer. Optional wait-limit counter is built
// only when SEQ_BUS_TIMEOUT_EN is defined.
module seq_bus_port #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic ack,
  output logic req,
  output logic done,
  output logic timeout
);

  // Handshake: req stays high every cycle the owner sits in its wait state;
  // a cycle with req && ack completes the transfer (zero-wait allowed), ack
  // without req is ignored, and reset removes req combinationally.
  assign req  = en & rst_n;
  assign done = en & ack;

`ifdef SEQ_BUS_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 255) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt;

  // Idle cycles between wait states clear the counter, giving a clean start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     cnt <= '0;
    else if (!en)                   cnt <= '0;
    else if (!ack && cnt != LIMIT)  cnt <= cnt + 1'b1;
  end

  assign timeout = en & ~ack & (cnt == LIMIT);
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = {31'(TIMEOUT_CYC), clk};
  assign timeout    = 1'b0;
`endif

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback.
// Optional bus timeout under SEQ_BUS_TIMEOUT_EN.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int              PC_W        = 64,
  parameter int              INST_BYTES  = 9,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            i_req,
  output logic [PC_W-1:0] i_addr,
  input  logic            i_ack,
  input  logic [71:0]     i_data,
  output logic            d_req,
  output logic            d_we,
  input  logic            d_ack,
  output logic [7:0]      ir_opc,
  output logic [63:0]     ir_opl,
  output logic            alu_en,
  output logic            rf_we,
  output logic            sp_inc,
  output logic            sp_dec,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc,
  output logic            halted,
  output logic            fault,
  output seq_state_e      dbg_state
);

  seq_state_e      state, state_n;
  logic [PC_W-1:0] pc_n, pc_inc;
  op_class_e       cls;
  logic            i_done, i_to, d_done, d_to;

  seq_bus_port #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_ibus (
    .clk(clk), .rst_n(rst_n), .en(state == ST_FETCH), .ack(i_ack),
    .req(i_req), .done(i_done), .timeout(i_to)
  );

  seq_bus_port #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_dbus (
    .clk(clk), .rst_n(rst_n), .en(state == ST_MEM), .ack(d_ack),
    .req(d_req), .done(d_done), .timeout(d_to)
  );

  assign cls       = op_class(ir_opc);
  assign pc_inc    = pc + PC_W'(INST_BYTES);
  assign i_addr    = pc;
  assign halted    = (state == ST_HALTED);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      {ir_opc, ir_opl} <= '0;
    else if (i_done) {ir_opc, ir_opl} <= i_data;
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    alu_en  = 1'b0;
    rf_we   = 1'b0;
    sp_inc  = 1'b0;
    sp_dec  = 1'b0;
    d_we    = 1'b0;
    unique case (state)
      ST_FETCH: begin
        if (i_done)    state_n = ST_DECODE;
        else if (i_to) state_n = ST_HALTED;
      end
      ST_DECODE: state_n = (cls == CLS_HALT) ? ST_HALTED : ST_EXEC;
      ST_EXEC: begin
        alu_en = 1'b1;
        sp_dec = (cls == CLS_PUSH);
        if (cls == CLS_JMP) begin
          pc_n    = br_taken ? br_target : pc_inc;
          state_n = ST_FETCH;
        end else if (cls == CLS_ALU) begin
          state_n = ST_WB;
        end else begin
          state_n = ST_MEM;
        end
      end
      ST_MEM: begin
        d_we = (cls == CLS_STORE) || (cls == CLS_PUSH);
        if (d_done) begin
          if (cls == CLS_LOAD || cls == CLS_POP) begin
            state_n = ST_WB;
          end else begin
            pc_n    = pc_inc;
            state_n = ST_FETCH;
          end
        end else if (d_to) begin
          state_n = ST_HALTED;
        end
      end
      ST_WB: begin
        rf_we   = 1'b1;
        sp_inc  = (cls == CLS_POP);
        pc_n    = pc_inc;
        state_n = ST_FETCH;
      end
      ST_HALTED: state_n = ST_HALTED;
      default:   state_n = ST_FETCH;
    endcase
  end

`ifdef SEQ_BUS_TIMEOUT_EN
  logic fault_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           fault_q <= 1'b0;
    else if (i_to | d_to) fault_q <= 1'b1;
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

endmodule
